// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM state encoding,
// HRESP response codes and HTRANS transfer-type codes.
package apb_bridge_pkg;

   // 3-bit encoding of the bridge controller FSM
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WWAIT    = 3'd1,
      ST_READ     = 3'd2,
      ST_WRITE    = 3'd3,
      ST_WRITEP   = 3'd4,
      ST_RENABLE  = 3'd5,
      ST_WENABLE  = 3'd6,
      ST_WENABLEP = 3'd7
   } state_t;

   // AHB response codes
   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   // AHB transfer types
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // True for the three APB access (enable) phase states
   function automatic logic is_enable_state(input state_t st);
      return (st == ST_RENABLE) || (st == ST_WENABLE) || (st == ST_WENABLEP);
   endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge controller FSM. Turns decoded AHB transfers into APB
// setup/enable cycles, pipelining back-to-back writes.
// Optional macro APB_FSM_SLVERR_EN adds Pslverr input and Hresp output.
module apb_fsm_controller
   import apb_bridge_pkg::*;
(
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        valid,
   input  logic        Hwrite,
   input  logic        Hwritereg,
   input  logic [31:0] Haddr,
   input  logic [31:0] Haddr1,
   input  logic [31:0] Haddr2,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Hwdata1,
   input  logic [2:0]  tempselx,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic        Hreadyout
`ifdef APB_FSM_SLVERR_EN
   ,
   input  logic        Pslverr,
   output logic [1:0]  Hresp
`endif
);

   state_t      r_state;
   state_t      w_next_state;
   logic [2:0]  r_pselx;
   logic        r_penable;
   logic        r_pwrite;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   logic        r_hreadyout;

   // Next-state decode from current state and AHB-side qualifiers
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (valid && Hwrite)       w_next_state = ST_WWAIT;
            else if (valid)            w_next_state = ST_READ;
            else                       w_next_state = ST_IDLE;
         end
         ST_WWAIT: begin
            if (valid)                 w_next_state = ST_WRITEP;
            else                       w_next_state = ST_WRITE;
         end
         ST_READ:                      w_next_state = ST_RENABLE;
         ST_WRITE: begin
            if (valid)                 w_next_state = ST_WENABLEP;
            else                       w_next_state = ST_WENABLE;
         end
         ST_WRITEP:                    w_next_state = ST_WENABLEP;
         ST_RENABLE, ST_WENABLE: begin
            if (valid && !Hwrite)      w_next_state = ST_READ;
            else if (valid)            w_next_state = ST_WWAIT;
            else                       w_next_state = ST_IDLE;
         end
         ST_WENABLEP: begin
            if (!Hwritereg)            w_next_state = ST_READ;
            else if (valid)            w_next_state = ST_WRITEP;
            else                       w_next_state = ST_WRITE;
         end
         default:                      w_next_state = ST_IDLE;
      endcase
   end

   // State register plus APB outputs registered from the state being entered
   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         r_state     <= ST_IDLE;
         r_pselx     <= 3'b000;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= 32'h0000_0000;
         r_pwdata    <= 32'h0000_0000;
         r_hreadyout <= 1'b1;
      end else begin
         r_state <= w_next_state;
         case (w_next_state)
            ST_IDLE, ST_WWAIT: begin
               // Address, data and direction hold their last values
               r_pselx     <= 3'b000;
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b1;
            end
            ST_READ: begin
               r_pselx     <= tempselx;
               r_paddr     <= Haddr;
               r_pwrite    <= 1'b0;
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b0;
            end
            ST_WRITE: begin
               r_pselx     <= tempselx;
               r_paddr     <= Haddr1;
               r_pwdata    <= Hwdata;
               r_pwrite    <= 1'b1;
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b0;
            end
            ST_WRITEP: begin
               // Pipelined write: address/data are one stage further back
               r_pselx     <= tempselx;
               r_paddr     <= Haddr2;
               r_pwdata    <= Hwdata1;
               r_pwrite    <= 1'b1;
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b0;
            end
            ST_RENABLE, ST_WENABLE: begin
               r_penable   <= 1'b1;
               r_hreadyout <= 1'b1;
            end
            ST_WENABLEP: begin
               // Another write is queued, so keep AHB stalled
               r_penable   <= 1'b1;
               r_hreadyout <= 1'b0;
            end
            default: begin
               r_pselx     <= 3'b000;
               r_penable   <= 1'b0;
               r_hreadyout <= 1'b1;
            end
         endcase
      end
   end

   assign Pselx     = r_pselx;
   assign Penable   = r_penable;
   assign Pwrite    = r_pwrite;
   assign Paddr     = r_paddr;
   assign Pwdata    = r_pwdata;
   assign Hreadyout = r_hreadyout;

`ifdef APB_FSM_SLVERR_EN
   logic [1:0] r_hresp;

   // Report an APB slave error back to AHB for the cycle after the enable phase
   always_ff @(posedge Hclk) begin
      if (!Hresetn) begin
         r_hresp <= HRESP_OKAY;
      end else if (is_enable_state(r_state) && Pslverr) begin
         r_hresp <= HRESP_ERROR;
      end else begin
         r_hresp <= HRESP_OKAY;
      end
   end

   assign Hresp = r_hresp;
`endif

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed scoreboard bench for apb_fsm_controller.
module tb_apb_fsm_controller;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic        valid;
   logic        Hwrite;
   logic        Hwritereg;
   logic [31:0] Haddr, Haddr1, Haddr2;
   logic [31:0] Hwdata, Hwdata1;
   logic [2:0]  tempselx;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic        Hreadyout;
   logic        Pslverr;
   logic [1:0]  Hresp;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [2:0]  psel;
      logic        pen;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        hready;
      logic [1:0]  hresp;
   } exp_t;

   exp_t exp_q[$];

   always #5 Hclk = ~Hclk;

   apb_fsm_controller dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .valid     (valid),
      .Hwrite    (Hwrite),
      .Hwritereg (Hwritereg),
      .Haddr     (Haddr),
      .Haddr1    (Haddr1),
      .Haddr2    (Haddr2),
      .Hwdata    (Hwdata),
      .Hwdata1   (Hwdata1),
      .tempselx  (tempselx),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Hreadyout (Hreadyout)
`ifdef APB_FSM_SLVERR_EN
      ,
      .Pslverr   (Pslverr),
      .Hresp     (Hresp)
`endif
   );

`ifndef APB_FSM_SLVERR_EN
   assign Hresp = 2'b00;
`endif

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input string nm, input logic rstn, input logic v, input logic hw,
                       input logic hwr, input logic [2:0] sel,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic slv,
                       input logic [2:0] e_psel, input logic e_pen, input logic e_pw,
                       input logic [31:0] e_pa, input logic [31:0] e_pd,
                       input logic e_rdy, input logic [1:0] e_resp);
      exp_t e;
      @(negedge Hclk);
      Hresetn = rstn; valid = v; Hwrite = hw; Hwritereg = hwr; tempselx = sel;
      Haddr = a0; Haddr1 = a1; Haddr2 = a2; Hwdata = d0; Hwdata1 = d1; Pslverr = slv;
      e.name = nm; e.psel = e_psel; e.pen = e_pen; e.pwrite = e_pw;
      e.paddr = e_pa; e.pwdata = e_pd; e.hready = e_rdy; e.hresp = e_resp;
      exp_q.push_back(e);
   endtask

   // Monitor: after each edge compare DUT outputs against the oldest expectation
   initial begin
      exp_t e;
      logic ok;
      forever begin
         @(posedge Hclk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (Pselx === e.psel) && (Penable === e.pen) && (Pwrite === e.pwrite) &&
                 (Paddr === e.paddr) && (Pwdata === e.pwdata) && (Hreadyout === e.hready);
`ifdef APB_FSM_SLVERR_EN
            ok = ok && (Hresp === e.hresp);
`endif
            n_tests++;
            if (!ok) begin
               n_fail++;
               $display("FAIL %s: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdy=%b resp=%b, want psel=%b pen=%b pw=%b paddr=%h pwdata=%h rdy=%b resp=%b",
                        e.name, Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout, Hresp,
                        e.psel, e.pen, e.pwrite, e.paddr, e.pwdata, e.hready, e.hresp);
            end
         end
      end
   end

   localparam logic [31:0] Z = 32'h0000_0000;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   initial begin
      Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0; tempselx = 3'b000;
      Haddr = Z; Haddr1 = Z; Haddr2 = Z; Hwdata = Z; Hwdata1 = Z; Pslverr = 1'b0;

      //   name          rst v  hw hwr sel     Haddr          Haddr1         Haddr2         Hwdata         Hwdata1        slv   psel    pen  pw   Paddr          Pwdata         rdy  resp
      step("reset",      0, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      step("idle",       1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      // Single write
      step("wr_wwait",   1, 1, 1, 0, 3'b001, 32'h8000_0001, Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      step("wr_setup",   1, 0, 0, 1, 3'b001, Z,             32'h8000_0001, Z,             DB,            Z,             0,    3'b001, 0,   1,   32'h8000_0001, DB,            0,   2'b00);
      step("wr_enable",  1, 0, 0, 0, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b001, 1,   1,   32'h8000_0001, DB,            1,   2'b00);
      step("wr_idle",    1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   1,   32'h8000_0001, DB,            1,   2'b00);
      // Single read, slave error during its enable cycle
      step("rd_setup",   1, 1, 0, 0, 3'b010, 32'h8000_0002, Z,             Z,             Z,             Z,             0,    3'b010, 0,   0,   32'h8000_0002, DB,            0,   2'b00);
      step("rd_enable",  1, 0, 0, 0, 3'b010, Z,             Z,             Z,             Z,             Z,             0,    3'b010, 1,   0,   32'h8000_0002, DB,            1,   2'b00);
      step("rd_idle",    1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             1,    3'b000, 0,   0,   32'h8000_0002, DB,            1,   2'b01);
      step("resp_clear", 1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             1,    3'b000, 0,   0,   32'h8000_0002, DB,            1,   2'b00);
      // Back-to-back writes then a read
      step("bb_wwait",   1, 1, 1, 0, 3'b100, 32'h8000_0010, Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   32'h8000_0002, DB,            1,   2'b00);
      step("bb_write",   1, 0, 0, 1, 3'b100, Z,             32'h8000_0010, Z,             32'h1111_1111, Z,             0,    3'b100, 0,   1,   32'h8000_0010, 32'h1111_1111, 0,   2'b00);
      step("bb_wenp1",   1, 1, 1, 0, 3'b100, 32'h8000_0014, Z,             Z,             Z,             Z,             0,    3'b100, 1,   1,   32'h8000_0010, 32'h1111_1111, 0,   2'b00);
      step("bb_writep",  1, 1, 0, 1, 3'b100, 32'h8000_0020, Z,             32'h8000_0014, Z,             32'h2222_2222, 0,    3'b100, 0,   1,   32'h8000_0014, 32'h2222_2222, 0,   2'b00);
      step("bb_wenp2",   1, 0, 0, 0, 3'b100, Z,             Z,             Z,             Z,             Z,             0,    3'b100, 1,   1,   32'h8000_0014, 32'h2222_2222, 0,   2'b00);
      step("wr2rd_set",  1, 0, 0, 0, 3'b010, 32'h8000_0020, Z,             Z,             Z,             Z,             0,    3'b010, 0,   0,   32'h8000_0020, 32'h2222_2222, 0,   2'b00);
      step("wr2rd_en",   1, 0, 0, 0, 3'b010, Z,             Z,             Z,             Z,             Z,             0,    3'b010, 1,   0,   32'h8000_0020, 32'h2222_2222, 1,   2'b00);
      step("wr2rd_idle", 1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   32'h8000_0020, 32'h2222_2222, 1,   2'b00);
      // Reset during write enable
      step("rs_wwait",   1, 1, 1, 0, 3'b001, 32'h8000_0030, Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   32'h8000_0020, 32'h2222_2222, 1,   2'b00);
      step("rs_write",   1, 0, 0, 1, 3'b001, Z,             32'h8000_0030, Z,             32'h3333_3333, Z,             0,    3'b001, 0,   1,   32'h8000_0030, 32'h3333_3333, 0,   2'b00);
      step("rs_wenable", 1, 0, 0, 0, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b001, 1,   1,   32'h8000_0030, 32'h3333_3333, 1,   2'b00);
      step("rs_assert",  0, 1, 0, 1, 3'b001, 32'h8000_0034, Z,             Z,             Z,             Z,             1,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      step("rs_rel1",    1, 0, 0, 0, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      step("rs_rel2",    1, 0, 0, 0, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      // WWAIT with valid goes straight to the pipelined write, then WENABLEP -> WRITE
      step("p_wwait",    1, 1, 1, 0, 3'b001, 32'h8000_0040, Z,             Z,             Z,             Z,             0,    3'b000, 0,   0,   Z,             Z,             1,   2'b00);
      step("p_writep",   1, 1, 1, 1, 3'b001, 32'h8000_0044, Z,             32'h8000_0040, Z,             32'h4444_4444, 0,    3'b001, 0,   1,   32'h8000_0040, 32'h4444_4444, 0,   2'b00);
      step("p_wenp",     1, 0, 0, 1, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b001, 1,   1,   32'h8000_0040, 32'h4444_4444, 0,   2'b00);
      step("p_write",    1, 0, 0, 1, 3'b001, Z,             32'h8000_0044, Z,             32'h5555_5555, Z,             0,    3'b001, 0,   1,   32'h8000_0044, 32'h5555_5555, 0,   2'b00);
      step("p_wenable",  1, 0, 0, 0, 3'b001, Z,             Z,             Z,             Z,             Z,             0,    3'b001, 1,   1,   32'h8000_0044, 32'h5555_5555, 1,   2'b00);
      step("p_idle",     1, 0, 0, 0, 3'b000, Z,             Z,             Z,             Z,             Z,             0,    3'b000, 0,   1,   32'h8000_0044, 32'h5555_5555, 1,   2'b00);

      // Let the monitor drain the scoreboard, bounded
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge Hclk);
         #2;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_fsm_controller.md
APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: Hclk (all state changes on rising edge) and Hresetn (sampled only on a rising Hclk edge).
REQ-002 Hclk  in  1  AHB/APB bridge clock.
REQ-003 Hresetn  in  1  synchronous active-low reset.
REQ-004 valid  in  1  legal AHB NONSEQ/SEQ transfer to bridge address range.
REQ-005 Hwrite  in  1  current address-phase direction; Hwritereg  in  1  direction registered one cycle earlier.
REQ-006 Haddr, Haddr1, Haddr2  in  32 each  current, one-cycle-delayed and two-cycle-delayed address.
REQ-007 Hwdata, Hwdata1  in  32 each  current and one-cycle-delayed write data.
REQ-008 tempselx  in  3  one-hot peripheral select decoded from address.
REQ-009 Pselx  out  3;  Penable  out  1;  Pwrite  out  1;  Paddr  out  32;  Pwdata  out  32  APB master signals.
REQ-010 Hreadyout  out  1  bridge ready back to AHB; 1 = accept next transfer.

Function
REQ-011 SHALL implement an 8-state FSM: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
REQ-012 ST_IDLE: valid&Hwrite -> ST_WWAIT; valid&~Hwrite -> ST_READ; else stay.
REQ-013 ST_WWAIT: valid -> ST_WRITEP; else -> ST_WRITE.
REQ-014 ST_READ -> ST_RENABLE unconditionally.
REQ-015 ST_WRITE: valid -> ST_WENABLEP; else -> ST_WENABLE.  ST_WRITEP -> ST_WENABLEP unconditionally.
REQ-016 ST_RENABLE and ST_WENABLE: valid&~Hwrite -> ST_READ; valid&Hwrite -> ST_WWAIT; else -> ST_IDLE.
REQ-017 ST_WENABLEP: ~Hwritereg -> ST_READ; Hwritereg&valid -> ST_WRITEP; Hwritereg&~valid -> ST_WRITE.
REQ-018 All outputs SHALL be registered, computed from next state, so values hold throughout the cycle the FSM is in that state.
REQ-019 ST_IDLE, ST_WWAIT: Pselx=0, Penable=0, Hreadyout=1; Paddr/Pwdata/Pwrite hold.
REQ-020 ST_READ: Pselx=tempselx, Paddr=Haddr, Pwrite=0, Penable=0, Hreadyout=0.
REQ-021 ST_WRITE: Pselx=tempselx, Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Penable=0, Hreadyout=0.
REQ-022 ST_WRITEP: Pselx=tempselx, Paddr=Haddr2, Pwdata=Hwdata1, Pwrite=1, Penable=0, Hreadyout=0.
REQ-023 ENABLE states: Penable=1, Pselx/Paddr/Pwdata/Pwrite held from preceding setup state; Hreadyout=1 in ST_RENABLE/ST_WENABLE, 0 in ST_WENABLEP.
REQ-024 Every APB access SHALL be exactly one setup cycle followed by one enable cycle; Penable SHALL never assert while Pselx=0.
REQ-025 Latency: read setup 1 cycle after valid sampled in ST_IDLE; write setup 2 cycles after (ST_WWAIT for data phase).
REQ-026 Back-to-back writes SHALL be pipelined via ST_WRITEP/ST_WENABLEP with no idle cycle between APB accesses.

Reset
REQ-027 Hresetn=0 at a rising edge SHALL force ST_IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1 on that edge.
REQ-028 Reset mid-access (any state) SHALL abort the access; no Penable pulse follows reset release until a new valid.

Configuration
REQ-029 Macro APB_FSM_SLVERR_EN: when defined, adds input Pslverr (1) and output Hresp (2); Pslverr sampled in ENABLE states sets Hresp=2'b01 for one cycle, else Hresp=2'b00; reset value 2'b00.
REQ-030 Without APB_FSM_SLVERR_EN neither port exists and behaviour is otherwise identical.

Structure
REQ-031 Shared package apb_bridge_pkg SHALL hold the 3-bit state typedef/encodings, HRESP constants (OKAY=2'b00, ERROR=2'b01) and HTRANS constants.
REQ-032 No sub-module; next-state logic and output register live in apb_fsm_controller.

Verification
REQ-033 Single write: valid=1,Hwrite=1,tempselx=3'b001,Haddr=32'h8000_0001 for one cycle, Hwdata=32'hDEADBEEF next -> ST_WRITE Pselx=001,Paddr=32'h8000_0001,Pwdata=32'hDEADBEEF,Pwrite=1; next cycle Penable=1, Hreadyout=1.
REQ-034 Single read: valid=1,Hwrite=0,Haddr=32'h8000_0002,tempselx=3'b010 -> next cycle Pselx=010,Paddr=32'h8000_0002,Pwrite=0,Hreadyout=0; following cycle Penable=1,Hreadyout=1; then ST_IDLE.
REQ-035 Two back-to-back writes (0x8000_0010,0x8000_0014) -> ST_WRITE/ST_WENABLEP/ST_WRITEP sequence, Paddr 0x8000_0010 then 0x8000_0014, no idle cycle between.
REQ-036 Write followed by read -> ST_WENABLEP -> ST_READ, Pwrite 1->0, addresses correct.
REQ-037 Hresetn=0 during ST_WENABLE -> next edge all outputs at reset values, Hreadyout=1, no further Penable.
REQ-038 With APB_FSM_SLVERR_EN, Pslverr=1 in read enable cycle -> Hresp=2'b01 for exactly one cycle, then 2'b00.
